// File: rtl/me_search_engine_if.sv
// Bus bundle for the full-search motion estimator: start request, reference and
// search memory read ports, and the result outputs.
// master = the estimator itself, slave = the environment (memories + requester).
interface me_search_engine_if #(
    parameter int PIX_W = 8,
    parameter int BLK   = 16,
    parameter int RANGE = 8
);
    localparam int WIN    = BLK + 2 * RANGE;
    localparam int AR_W   = $clog2(BLK * BLK);
    localparam int AS_W   = $clog2(WIN * WIN);
    localparam int DIST_W = PIX_W + $clog2(BLK * BLK);
    localparam int MV_W   = $clog2(RANGE + 1) + 1;

    logic                     start;
    logic [AR_W-1:0]          AddressR;
    logic [PIX_W-1:0]         R;
    logic [AS_W-1:0]          AddressS;
    logic [PIX_W-1:0]         S;
    logic [DIST_W-1:0]        BestDist;
    logic signed [MV_W-1:0]   motionX;
    logic signed [MV_W-1:0]   motionY;
    logic                     completed;

    modport master (
        input  start, R, S,
        output AddressR, AddressS, BestDist, motionX, motionY, completed
    );

    modport slave (
        output start, R, S,
        input  AddressR, AddressS, BestDist, motionX, motionY, completed
    );
endinterface

// File: rtl/me_search_engine.sv
// Full-search block-matching motion estimator.
// For each displacement (dx,dy) in +/-RANGE (dy outer, dx inner) the BLKxBLK
// reference block is compared with the search window by SAD; the smallest SAD
// (earliest candidate on ties) and its vector are reported.
// Both memories have a one-cycle synchronous read latency, so each candidate
// takes BLK*BLK issue cycles, one drain cycle and one compare cycle.
// Optional macro EARLY_TERM_EN: abandon a candidate as soon as its partial SAD
// can no longer beat the best so far (results unchanged, latency shorter).
module me_search_engine #(
    parameter int PIX_W = 8,
    parameter int BLK   = 16,
    parameter int RANGE = 8
) (
    input  logic               clock,
    input  logic               reset,
    me_search_engine_if.master bus
);
    localparam int WIN    = BLK + 2 * RANGE;
    localparam int AR_W   = $clog2(BLK * BLK);
    localparam int AS_W   = $clog2(WIN * WIN);
    localparam int DIST_W = PIX_W + $clog2(BLK * BLK);
    localparam int MV_W   = $clog2(RANGE + 1) + 1;
    localparam int NCAND  = 2 * RANGE + 1;
    localparam int OFF_W  = $clog2(NCAND);
    localparam int RC_W   = $clog2(BLK);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CMP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   start_q, start_d;
    logic [RC_W-1:0]        row_q, row_d, col_q, col_d;
    // Candidate offsets kept as 0..2*RANGE; the signed vector is offset-RANGE.
    logic [OFF_W-1:0]       ox_q, ox_d, oy_q, oy_d;
    logic [AR_W-1:0]        addr_r_q, addr_r_d;
    logic [AS_W-1:0]        addr_s_q, addr_s_d;
    logic                   valid_q, valid_d;
    logic [DIST_W-1:0]      accum_q, accum_d;
    logic [DIST_W-1:0]      best_q, best_d;
    logic signed [MV_W-1:0] mvx_q, mvx_d, mvy_q, mvy_d;
    logic                   done_q, done_d;

    logic                   rise_s;
    logic                   last_pix_s;
    logic                   last_cand_s;
    logic                   et_hit_s;
    logic                   issue_s;
    logic signed [PIX_W:0]  diff_s;
    logic signed [PIX_W:0]  neg_s;
    logic [PIX_W-1:0]       abs_s;

    assign rise_s      = bus.start & ~start_q;
    assign last_pix_s  = (row_q == RC_W'(BLK - 1)) && (col_q == RC_W'(BLK - 1));
    assign last_cand_s = (ox_q == OFF_W'(NCAND - 1)) && (oy_q == OFF_W'(NCAND - 1));

`ifdef EARLY_TERM_EN
    // Partial SAD already at or above the best: this candidate cannot win.
    assign et_hit_s = (accum_q >= best_q);
`else
    assign et_hit_s = 1'b0;
`endif

    // Absolute pixel difference: signed PIX_W+1 subtract, PIX_W-bit magnitude.
    always_comb begin
        diff_s = $signed({1'b0, bus.R}) - $signed({1'b0, bus.S});
        neg_s  = -diff_s;
        abs_s  = diff_s[PIX_W] ? neg_s[PIX_W-1:0] : diff_s[PIX_W-1:0];
    end

    // Next-state logic of the scan controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) state_d = ST_RUN;
                else        state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (et_hit_s)        state_d = ST_CMP;
                else if (last_pix_s) state_d = ST_DRAIN;
                else                 state_d = ST_RUN;
            end
            ST_DRAIN: state_d = ST_CMP;
            ST_CMP: begin
                if (last_cand_s) state_d = ST_DONE;
                else             state_d = ST_RUN;
            end
            ST_DONE: begin
                if (rise_s) state_d = ST_RUN;
                else        state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath / output next values: address generation, accumulation, compare.
    always_comb begin
        start_d  = bus.start;
        valid_d  = (state_q == ST_RUN);
        row_d    = row_q;
        col_d    = col_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        addr_r_d = addr_r_q;
        addr_s_d = addr_s_q;
        best_d   = best_q;
        mvx_d    = mvx_q;
        mvy_d    = mvy_q;
        done_d   = done_q;
        issue_s  = 1'b0;

        // Data returned this cycle belongs to an address issued last cycle.
        if (valid_q) accum_d = accum_q + DIST_W'(abs_s);
        else         accum_d = accum_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (rise_s) begin
                    best_d  = {DIST_W{1'b1}};
                    mvx_d   = {MV_W{1'b0}};
                    mvy_d   = {MV_W{1'b0}};
                    done_d  = 1'b0;
                    accum_d = {DIST_W{1'b0}};
                    ox_d    = {OFF_W{1'b0}};
                    oy_d    = {OFF_W{1'b0}};
                    row_d   = {RC_W{1'b0}};
                    col_d   = {RC_W{1'b0}};
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (et_hit_s) begin
                    issue_s = 1'b0;
                end else if (!last_pix_s) begin
                    if (col_q == RC_W'(BLK - 1)) begin
                        col_d = {RC_W{1'b0}};
                        row_d = row_q + RC_W'(1);
                    end else begin
                        col_d = col_q + RC_W'(1);
                    end
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                issue_s = 1'b0;
            end
            ST_CMP: begin
                // Strict compare keeps the earliest candidate on ties.
                if (accum_q < best_q) begin
                    best_d = accum_q;
                    mvx_d  = MV_W'(int'(ox_q) - RANGE);
                    mvy_d  = MV_W'(int'(oy_q) - RANGE);
                end else begin
                    best_d = best_q;
                end
                accum_d = {DIST_W{1'b0}};
                if (last_cand_s) begin
                    done_d = 1'b1;
                end else begin
                    if (ox_q == OFF_W'(NCAND - 1)) begin
                        ox_d = {OFF_W{1'b0}};
                        oy_d = oy_q + OFF_W'(1);
                    end else begin
                        ox_d = ox_q + OFF_W'(1);
                    end
                    row_d   = {RC_W{1'b0}};
                    col_d   = {RC_W{1'b0}};
                    issue_s = 1'b1;
                end
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase

        // Addresses only move when a new pixel is issued; otherwise they hold.
        if (issue_s) begin
            addr_r_d = AR_W'(int'(row_d) * BLK + int'(col_d));
            addr_s_d = AS_W'((int'(oy_d) + int'(row_d)) * WIN + int'(ox_d) + int'(col_d));
        end else begin
            addr_r_d = addr_r_q;
            addr_s_d = addr_s_q;
        end
    end

    // State and datapath registers; asynchronous reset discards any search.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            row_q    <= {RC_W{1'b0}};
            col_q    <= {RC_W{1'b0}};
            ox_q     <= {OFF_W{1'b0}};
            oy_q     <= {OFF_W{1'b0}};
            addr_r_q <= {AR_W{1'b0}};
            addr_s_q <= {AS_W{1'b0}};
            valid_q  <= 1'b0;
            accum_q  <= {DIST_W{1'b0}};
            best_q   <= {DIST_W{1'b1}};
            mvx_q    <= {MV_W{1'b0}};
            mvy_q    <= {MV_W{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            row_q    <= row_d;
            col_q    <= col_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            addr_r_q <= addr_r_d;
            addr_s_q <= addr_s_d;
            valid_q  <= valid_d;
            accum_q  <= accum_d;
            best_q   <= best_d;
            mvx_q    <= mvx_d;
            mvy_q    <= mvy_d;
            done_q   <= done_d;
        end
    end

    assign bus.AddressR  = addr_r_q;
    assign bus.AddressS  = addr_s_q;
    assign bus.BestDist  = best_q;
    assign bus.motionX   = mvx_q;
    assign bus.motionY   = mvy_q;
    assign bus.completed = done_q;
endmodule
